// File: rtl/mseq_sync_acq_if.sv
// Chip-stream and acquisition-status bundle between the M-sequence
// acquisition stage (slave) and its environment (master).
interface mseq_sync_acq_if;
    logic       init_load;
    logic [4:0] rx_m_state;
    logic       chip_in;
    logic       chip_valid;
    logic       sync_flag;
    logic [4:0] slip_count;
    logic       data_out;
    logic       data_valid;
    logic       acq_fail;

    modport master (
        output init_load, rx_m_state, chip_in, chip_valid,
        input  sync_flag, slip_count, data_out, data_valid, acq_fail
    );

    modport slave (
        input  init_load, rx_m_state, chip_in, chip_valid,
        output sync_flag, slip_count, data_out, data_valid, acq_fail
    );
endinterface

// File: rtl/mseq_sync_acq.sv
// Receive-side M-sequence acquisition: correlates 31-chip windows against a local
// x^5+x^2+1 LFSR, slips local phase one chip per failed window, tracks lock, despreads data.
module mseq_sync_acq #(
    parameter int unsigned THRESH   = 28,
    parameter int unsigned CONFIRM  = 2,
    parameter int unsigned LOSS_MAX = 2
) (
    input  logic           clk,
    input  logic           reset,
    mseq_sync_acq_if.slave bus
);
    localparam int unsigned SEQ_LEN   = 31;
    localparam logic [4:0]  LFSR_RST  = 5'b10101;
    localparam logic [4:0]  LAST_IDX  = 5'(SEQ_LEN - 1);
    localparam logic [4:0]  HI_THR    = 5'(THRESH);
    localparam logic [4:0]  LO_THR    = 5'(SEQ_LEN - THRESH);
    localparam logic [4:0]  HALF      = 5'(SEQ_LEN / 2);
    localparam logic [3:0]  CONF_N    = 4'(CONFIRM);
    localparam logic [3:0]  LOSS_N    = 4'(LOSS_MAX);
    localparam logic        ONE_SHOT  = (CONFIRM <= 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_SLIP    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCK    = 2'd3
    } state_t;

    state_t     state_r;
    logic [4:0] lfsr_r;
    logic [4:0] win_cnt_r;
    logic [4:0] agree_r;
    logic [4:0] slip_cnt_r;
    logic [3:0] pass_cnt_r;
    logic [3:0] fail_cnt_r;
    logic       sync_r;
    logic       data_out_r;
    logic       data_valid_r;
    logic       acq_fail_r;

    logic [4:0] agree_sum_s;
    logic       win_pass_s;
    logic       bit_val_s;
    logic       win_end_s;
    logic [3:0] pass_inc_s;
    logic [3:0] fail_inc_s;

    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {s[0] ^ s[2], s[4:1]};
    endfunction

    // The all-zero state is the LFSR lock-up state, so it is never loaded.
    function automatic logic [4:0] seed_fix(input logic [4:0] s);
        logic [4:0] r;
        if (s == 5'b00000) begin
            r = 5'b00001;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Low agreement also passes: that is the window carrying an inverted data bit.
    function automatic logic window_pass(input logic [4:0] a);
        return (a >= HI_THR) || (a <= LO_THR);
    endfunction

    // Window statistics including the chip presented this cycle.
    always_comb begin
        agree_sum_s = agree_r + {4'b0000, bus.chip_in ~^ lfsr_r[0]};
        win_pass_s  = window_pass(agree_sum_s);
        bit_val_s   = (agree_sum_s <= HALF);
        win_end_s   = (win_cnt_r == LAST_IDX);
        pass_inc_s  = pass_cnt_r + 4'd1;
        fail_inc_s  = fail_cnt_r + 4'd1;
    end

    // Acquisition/tracking state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_SEARCH;
            lfsr_r       <= LFSR_RST;
            win_cnt_r    <= 5'd0;
            agree_r      <= 5'd0;
            slip_cnt_r   <= 5'd0;
            pass_cnt_r   <= 4'd0;
            fail_cnt_r   <= 4'd0;
            sync_r       <= 1'b0;
            data_out_r   <= 1'b0;
            data_valid_r <= 1'b0;
            acq_fail_r   <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            acq_fail_r   <= 1'b0;
            if (bus.init_load) begin
                state_r    <= ST_SEARCH;
                lfsr_r     <= seed_fix(bus.rx_m_state);
                win_cnt_r  <= 5'd0;
                agree_r    <= 5'd0;
                slip_cnt_r <= 5'd0;
                pass_cnt_r <= 4'd0;
                fail_cnt_r <= 4'd0;
                sync_r     <= 1'b0;
            end else if (bus.chip_valid) begin
                case (state_r)
                    ST_SLIP: begin
                        // Discarded chip: the input moves on, the local phase does not.
                        if (slip_cnt_r == LAST_IDX) begin
                            slip_cnt_r <= 5'd0;
                            acq_fail_r <= 1'b1;
                        end else begin
                            slip_cnt_r <= slip_cnt_r + 5'd1;
                        end
                        win_cnt_r <= 5'd0;
                        agree_r   <= 5'd0;
                        state_r   <= ST_SEARCH;
                    end
                    ST_SEARCH, ST_CONFIRM, ST_LOCK: begin
                        lfsr_r <= lfsr_next(lfsr_r);
                        if (!win_end_s) begin
                            win_cnt_r <= win_cnt_r + 5'd1;
                            agree_r   <= agree_sum_s;
                        end else begin
                            win_cnt_r <= 5'd0;
                            agree_r   <= 5'd0;
                            if (state_r == ST_LOCK) begin
                                data_valid_r <= 1'b1;
                                data_out_r   <= bit_val_s;
                                if (win_pass_s) begin
                                    fail_cnt_r <= 4'd0;
                                end else if (fail_inc_s >= LOSS_N) begin
                                    fail_cnt_r <= 4'd0;
                                    pass_cnt_r <= 4'd0;
                                    sync_r     <= 1'b0;
                                    state_r    <= ST_SLIP;
                                end else begin
                                    fail_cnt_r <= fail_inc_s;
                                end
                            end else if (!win_pass_s) begin
                                pass_cnt_r <= 4'd0;
                                state_r    <= ST_SLIP;
                            end else if ((state_r == ST_SEARCH && ONE_SHOT) ||
                                         (state_r == ST_CONFIRM && pass_inc_s >= CONF_N)) begin
                                // The window that completes confirmation already carries data.
                                pass_cnt_r   <= pass_inc_s;
                                fail_cnt_r   <= 4'd0;
                                slip_cnt_r   <= 5'd0;
                                sync_r       <= 1'b1;
                                data_valid_r <= 1'b1;
                                data_out_r   <= bit_val_s;
                                state_r      <= ST_LOCK;
                            end else if (state_r == ST_SEARCH) begin
                                pass_cnt_r <= 4'd1;
                                state_r    <= ST_CONFIRM;
                            end else begin
                                pass_cnt_r <= pass_inc_s;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_SEARCH;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.sync_flag  = sync_r;
    assign bus.slip_count = slip_cnt_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.acq_fail   = acq_fail_r;
endmodule

// File: tb/tb_mseq_sync_acq.sv
// Bench for mseq_sync_acq: a phase-index/window-queue reference model predicts all
// outputs every cycle, plus absolute timing checks for each acquisition scenario.
module tb_mseq_sync_acq;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    mseq_sync_acq_if bus ();

    mseq_sync_acq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // mseq_st[p] is the generator state p chips after 10101
    logic [4:0] mseq_st [31];

    int         m_ph, m_slips, m_pass, m_fail;
    bit         m_lock, m_pend, m_do, m_dv, m_af;
    bit         m_win [$];
    logic [8:0] exp_v, obs_v;

    function automatic int phase_of(input logic [4:0] s);
        logic [4:0] t;
        int p;
        t = (s == 5'd0) ? 5'd1 : s;
        p = 0;
        for (int i = 0; i < 31; i++) begin
            if (mseq_st[i] == t) p = i;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_slips = 0; m_pass = 0; m_fail = 0;
        m_lock = 1'b0; m_pend = 1'b0; m_do = 1'b0; m_dv = 1'b0; m_af = 1'b0;
        m_win.delete();
        exp_v = 9'd0;
    endtask

    task automatic model_step(input bit v, input bit c, input bit ld, input logic [4:0] seed);
        int agree;
        bit ok;
        m_dv = 1'b0;
        m_af = 1'b0;
        if (ld) begin
            m_ph = phase_of(seed); m_slips = 0; m_pass = 0; m_fail = 0;
            m_lock = 1'b0; m_pend = 1'b0;
            m_win.delete();
        end else if (v && m_pend) begin
            m_pend  = 1'b0;
            m_slips = (m_slips + 1) % 31;
            m_af    = (m_slips == 0);
        end else if (v) begin
            m_win.push_back(c == mseq_st[m_ph][0]);
            m_ph = (m_ph + 1) % 31;
            if (m_win.size() == 31) begin
                agree = 0;
                foreach (m_win[i]) agree += int'(m_win[i]);
                m_win.delete();
                ok = (agree >= 28) || (agree <= 3);
                if (m_lock) begin
                    m_dv = 1'b1;
                    m_do = (agree <= 15);
                    if (ok) m_fail = 0;
                    else begin
                        m_fail++;
                        if (m_fail >= 2) begin
                            m_lock = 1'b0; m_fail = 0; m_pass = 0; m_pend = 1'b1;
                        end
                    end
                end else if (ok) begin
                    m_pass++;
                    if (m_pass >= 2) begin
                        m_lock = 1'b1; m_slips = 0; m_fail = 0; m_dv = 1'b1; m_do = (agree <= 15);
                    end
                end else begin
                    m_pass = 0;
                    m_pend = 1'b1;
                end
            end
        end
        exp_v = {m_lock, 5'(m_slips), m_do, m_dv, m_af};
    endtask

    task automatic step(input bit v, input bit c, input bit ld, input logic [4:0] seed);
        @(negedge clk);
        bus.chip_valid = v;
        bus.chip_in    = c;
        bus.init_load  = ld;
        bus.rx_m_state = seed;
        @(posedge clk);
        #1;
        model_step(v, c, ld, seed);
        obs_v = {bus.sync_flag, bus.slip_count, bus.data_out, bus.data_valid, bus.acq_fail};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.chip_valid = 1'b0;
        bus.init_load  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        obs_v = {bus.sync_flag, bus.slip_count, bus.data_out, bus.data_valid, bus.acq_fail};
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (obs_v !== 9'd0) begin
            n_bad++; $display("FAIL reset_outputs got=%b want=%b", obs_v, 9'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 5'd0);
            n_chk++;
            if (obs_v !== exp_v || obs_v !== 9'd0) begin
                n_bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_v, exp_v);
            end
        end
    endtask

    // Data bits 0,1,1 on a phase-aligned stream, optionally with a gap every other cycle.
    task automatic test_aligned(input bit gaps);
        bit dbits [3] = '{1'b0, 1'b1, 1'b1};
        int kv = 0, lock_at = 0, dv1 = -1, dv2 = -1;
        bit do1 = 1'b0, do2 = 1'b0;
        bit v;
        do_reset();
        for (int cyc = 0; cyc < (gaps ? 186 : 93); cyc++) begin
            v = !gaps || (cyc % 2 == 0);
            if (v) begin
                step(1'b1, mseq_st[kv % 31][0] ^ dbits[kv / 31], 1'b0, 5'd0);
                kv++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 5'd0);
            end
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL aligned_model gaps=%0d cyc=%0d got=%b want=%b", gaps, cyc, obs_v, exp_v);
            end
            if (bus.sync_flag && lock_at == 0) lock_at = kv;
            if (bus.data_valid && dv1 < 0) begin dv1 = kv; do1 = bus.data_out; end
            else if (bus.data_valid && dv2 < 0) begin dv2 = kv; do2 = bus.data_out; end
        end
        n_chk++;
        if (lock_at !== 62) begin
            n_bad++; $display("FAIL aligned_lock gaps=%0d got=%0d want=62", gaps, lock_at);
        end
        n_chk++;
        if (dv1 !== 62 || dv2 !== 93) begin
            n_bad++; $display("FAIL aligned_dv_chips gaps=%0d got=%0d,%0d want=62,93", gaps, dv1, dv2);
        end
        n_chk++;
        if (do1 !== 1'b1 || do2 !== 1'b1) begin
            n_bad++; $display("FAIL aligned_data gaps=%0d got=%b%b want=11", gaps, do1, do2);
        end
        n_chk++;
        if (bus.slip_count !== 5'd0) begin
            n_bad++; $display("FAIL aligned_slips gaps=%0d got=%0d want=0", gaps, bus.slip_count);
        end
    endtask

    task automatic test_offset();
        int lock_at = 0, af_n = 0;
        do_reset();
        for (int k = 0; k < 170; k++) begin
            step(1'b1, mseq_st[(28 + k) % 31][0], 1'b0, 5'd0);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL offset_model chip=%0d got=%b want=%b", k + 1, obs_v, exp_v);
            end
            if (bus.sync_flag && lock_at == 0) lock_at = k + 1;
            if (bus.acq_fail) af_n++;
            if (k == 95) begin
                n_chk++;
                if (bus.slip_count !== 5'd3) begin
                    n_bad++; $display("FAIL offset_slips got=%0d want=3", bus.slip_count);
                end
            end
        end
        n_chk++;
        if (lock_at !== 158) begin
            n_bad++; $display("FAIL offset_lock got=%0d want=158", lock_at);
        end
        n_chk++;
        if (af_n !== 0 || bus.slip_count !== 5'd0) begin
            n_bad++; $display("FAIL offset_acq_fail pulses=%0d slips=%0d want=0,0", af_n, bus.slip_count);
        end
    endtask

    task automatic test_noise();
        int nerr_tab [5] = '{2, 2, 2, 5, 5};
        bit keep_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit err [31];
        bit dbit;
        int cnt, p, dv_n, k;
        do_reset();
        k = 0;
        for (int i = 0; i < 62; i++) begin
            step(1'b1, mseq_st[k % 31][0], 1'b0, 5'd0);
            k++;
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL noise_lockup chip=%0d got=%b want=%b", k, obs_v, exp_v);
            end
        end
        dv_n = 0;
        for (int w = 0; w < 5; w++) begin
            for (int j = 0; j < 31; j++) err[j] = 1'b0;
            cnt = 0;
            while (cnt < nerr_tab[w]) begin
                p = $urandom_range(0, 30);
                if (!err[p]) begin err[p] = 1'b1; cnt++; end
            end
            dbit = 1'($urandom_range(0, 1));
            for (int j = 0; j < 31; j++) begin
                step(1'b1, mseq_st[k % 31][0] ^ dbit ^ err[j], 1'b0, 5'd0);
                k++;
                n_chk++;
                if (obs_v !== exp_v) begin
                    n_bad++; $display("FAIL noise_model chip=%0d got=%b want=%b", k, obs_v, exp_v);
                end
                if (bus.data_valid) dv_n++;
            end
            n_chk++;
            if (bus.sync_flag !== keep_tab[w]) begin
                n_bad++; $display("FAIL noise_sync window=%0d got=%b want=%b", w, bus.sync_flag, keep_tab[w]);
            end
        end
        n_chk++;
        if (dv_n !== 5) begin
            n_bad++; $display("FAIL noise_dv_count got=%0d want=5", dv_n);
        end
        step(1'b1, mseq_st[k % 31][0], 1'b0, 5'd0);
        n_chk++;
        if (bus.slip_count !== 5'd1 || bus.sync_flag !== 1'b0 || obs_v !== exp_v) begin
            n_bad++; $display("FAIL noise_slip got=%b want=%b", obs_v, exp_v);
        end
    endtask

    task automatic test_no_signal();
        int af_at = 0, af_n = 0;
        bit ever_lock = 1'b0;
        do_reset();
        for (int k = 1; k <= 1000; k++) begin
            step(1'b1, 1'b0, 1'b0, 5'd0);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL nosig_model chip=%0d got=%b want=%b", k, obs_v, exp_v);
            end
            if (bus.acq_fail) begin af_n++; if (af_at == 0) af_at = k; end
            if (bus.sync_flag) ever_lock = 1'b1;
            if (k == 960 || k == 992) begin
                n_chk++;
                if (bus.slip_count !== ((k == 960) ? 5'd30 : 5'd0)) begin
                    n_bad++; $display("FAIL nosig_slips chip=%0d got=%0d", k, bus.slip_count);
                end
            end
        end
        n_chk++;
        if (af_at !== 992 || af_n !== 1) begin
            n_bad++; $display("FAIL nosig_acq_fail at=%0d pulses=%0d want=992,1", af_at, af_n);
        end
        n_chk++;
        if (ever_lock !== 1'b0) begin
            n_bad++; $display("FAIL nosig_lock got=%b want=0", ever_lock);
        end
    endtask

    task automatic test_reload();
        int p1, lock_at;
        do_reset();
        for (int k = 0; k < 67; k++) begin
            step(1'b1, mseq_st[k % 31][0], 1'b0, 5'd0);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL reload_pre chip=%0d got=%b want=%b", k + 1, obs_v, exp_v);
            end
        end
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 5'd0);
        n_chk++;
        if (bus.sync_flag !== 1'b0 || bus.slip_count !== 5'd0 || obs_v !== exp_v) begin
            n_bad++; $display("FAIL reload_drop got=%b want=%b", obs_v, exp_v);
        end
        p1 = phase_of(5'b00001);
        lock_at = 0;
        for (int k = 0; k < 70; k++) begin
            step(1'b1, mseq_st[(p1 + k) % 31][0], 1'b0, 5'd0);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_bad++; $display("FAIL reload_model chip=%0d got=%b want=%b", k + 1, obs_v, exp_v);
            end
            if (bus.sync_flag && lock_at == 0) lock_at = k + 1;
        end
        n_chk++;
        if (lock_at !== 62) begin
            n_bad++; $display("FAIL reload_lock got=%0d want=62", lock_at);
        end
        // Reset together with a load and a valid chip while locked.
        @(negedge clk);
        reset = 1'b1; bus.init_load = 1'b1; bus.chip_valid = 1'b1; bus.rx_m_state = 5'd7;
        @(posedge clk);
        #1;
        obs_v = {bus.sync_flag, bus.slip_count, bus.data_out, bus.data_valid, bus.acq_fail};
        n_chk++;
        if (obs_v !== 9'd0) begin
            n_bad++; $display("FAIL reset_override got=%b want=%b", obs_v, 9'd0);
        end
        do_reset();
    endtask

    // Random offsets, data, gaps, sparse chip errors and mid-run reloads.
    task automatic test_random();
        int d, k;
        bit dbit, v, ld;
        logic [4:0] seed;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            d = $urandom_range(0, 30);
            k = 0;
            dbit = 1'b0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                ld = (it % 2 == 1) && (cyc == 300);
                v  = ($urandom_range(0, 3) != 0);
                if (ld) begin
                    seed = 5'($urandom_range(0, 31));
                    step(v, 1'($urandom_range(0, 1)), 1'b1, seed);
                    d = (phase_of(seed) + $urandom_range(0, 30)) % 31;
                    k = 0;
                end else if (v) begin
                    if ((d + k) % 31 == 0) dbit = 1'($urandom_range(0, 1));
                    step(1'b1, mseq_st[(d + k) % 31][0] ^ dbit ^ ($urandom_range(0, 49) == 0), 1'b0, 5'd0);
                    k++;
                end else begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 5'd0);
                end
                n_chk++;
                if (obs_v !== exp_v) begin
                    n_bad++; $display("FAIL random_model it=%0d cyc=%0d got=%b want=%b", it, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        logic [4:0] s;
        bus.init_load  = 1'b0;
        bus.rx_m_state = 5'd0;
        bus.chip_in    = 1'b0;
        bus.chip_valid = 1'b0;
        s = 5'b10101;
        for (int i = 0; i < 31; i++) begin
            mseq_st[i] = s;
            s = {s[0] ^ s[2], s[4:1]};
        end
        model_reset();
        test_reset();
        test_aligned(1'b0);
        test_aligned(1'b1);
        test_offset();
        test_noise();
        test_no_signal();
        test_reload();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
